// File: rtl/anc_pkg.sv
// Shared definitions for the ANC inner-product frame sequencer.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
// Contents: frame index type, frame/tap/read boundary indices, sequencer state enum.
package anc_pkg;

  // Frame index driven to the accumulator and used as the tap address.
  typedef logic [6:0] frame_t;

  // Last frame index.
  localparam frame_t FRAME_LAST = 7'd127;
  // Last frame in which the accumulator adds a product.
  localparam frame_t TAP_LAST   = 7'd126;
  // Last frame that issues a memory read.
  localparam frame_t RD_LAST    = 7'd125;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/anc_frame_cnt.sv
// 7-bit frame counter with synchronous reset, load-to-zero and a terminal flag at 127.
// Latency: count updates on the edge after en/load_zero; last is combinational from the count.
// Backpressure: none; the count advances whenever en is high.
// Ports:
//   clk        in  1  clock
//   rst_n      in  1  synchronous active-low reset (count -> 0)
//   load_zero  in  1  load the count with 0 (takes priority over en)
//   en         in  1  increment enable
//   cnt        out 7  current count
//   last       out 1  high while cnt == 127
module anc_frame_cnt
  import anc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_zero,
  input  logic       en,
  output logic [6:0] cnt,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_zero) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 7'd1;
    end
  end

  assign last = (cnt == FRAME_LAST);

endmodule

// File: rtl/anc_inp_seq.sv
// Frame sequencer for the ANC inner-product accumulator: 128-cycle frame per start, rescaled output at frame end.
// Latency: start at cycle t -> frame 0 at t+1, frame 127 at t+128, y_valid at t+129.
// Backpressure: none; a start during a frame (except at frame 127) is dropped and flagged on overrun.
// Ports:
//   clk      in  1          clock, rising edge
//   rst_n    in  1          synchronous active-low reset
//   start    in  1          new-sample strobe
//   frame    out 7          frame index to the accumulator
//   rd_en    out 1          coefficient/sample memory read enable
//   rd_addr  out 7          tap address shared by both memories
//   acc_in   in  ACC_WIDTH  accumulator output, signed
//   y_out    out Y_WIDTH    filter output, signed, registered
//   y_valid  out 1          one-cycle pulse when y_out updates
//   busy     out 1          frame in progress
//   overrun  out 1          one-cycle pulse when start is rejected
//   sat      out 1          one-cycle pulse with y_valid when the output clipped
// Build option: define ANC_INP_SEQ_SAT_EN to clamp the output (and drive sat);
// otherwise the output wraps to Y_WIDTH bits and sat stays 0.
module anc_inp_seq
  import anc_pkg::*;
#(
  parameter int ACC_WIDTH = 40,
  parameter int Y_WIDTH   = 16,
  parameter int SHIFT     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [6:0]           frame,
  output logic                 rd_en,
  output logic [6:0]           rd_addr,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [Y_WIDTH-1:0]   y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 sat
);

  state_t             state;
  logic   [6:0]       cnt;
  logic               cnt_last;
  logic               cnt_en;
  logic               cnt_load_zero;

  // Counter only runs in RUN; it is forced back to 0 at frame 127 whether
  // the next cycle is IDLE or the first cycle of a back-to-back frame.
  assign cnt_en        = (state == RUN);
  assign cnt_load_zero = (state == RUN) && cnt_last;

  anc_frame_cnt u_frame_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (cnt_load_zero),
    .en        (cnt_en),
    .cnt       (cnt),
    .last      (cnt_last)
  );

  assign frame = cnt;

  // Reads cover taps 0..125 only; data arrives one frame later, so the last
  // product lands in frame 126 and frames 126/127 need no read.
  assign rd_en   = (state == RUN) && (cnt <= RD_LAST);
  assign rd_addr = rd_en ? cnt : 7'd0;

  // Floor division by 2^SHIFT.
  logic signed [ACC_WIDTH-1:0] acc_shr;
  logic        [Y_WIDTH-1:0]   y_next;
  logic                        clip;

  assign acc_shr = $signed(acc_in) >>> SHIFT;

`ifdef ANC_INP_SEQ_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-Y_WIDTH+1){1'b0}}, {(Y_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
    {{(ACC_WIDTH-Y_WIDTH+1){1'b1}}, {(Y_WIDTH-1){1'b0}}};

  logic clip_hi;
  logic clip_lo;

  assign clip_hi = (acc_shr > Y_MAX);
  assign clip_lo = (acc_shr < Y_MIN);
  assign clip    = clip_hi || clip_lo;

  always_comb begin
    y_next = acc_shr[Y_WIDTH-1:0];
    if (clip_hi) begin
      y_next = Y_MAX[Y_WIDTH-1:0];
    end else if (clip_lo) begin
      y_next = Y_MIN[Y_WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap: the bits above Y_WIDTH are simply dropped.
  logic unused_acc_hi;

  assign unused_acc_hi = ^acc_shr[ACC_WIDTH-1:Y_WIDTH];
  assign y_next        = acc_shr[Y_WIDTH-1:0];
  assign clip          = 1'b0;
`endif

  // Sequencer FSM with registered status/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      sat     <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_last) begin
            // acc_in holds the full sum of taps 0..125 during frame 127.
            y_out   <= y_next;
            y_valid <= 1'b1;
            sat     <= clip;
            if (!start) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/anc_inp_seq.md
# anc_inp_seq

Frame sequencer for the ANC inner-product accumulator. Each new-sample strobe starts one 128-cycle frame. During the frame the block drives the 7-bit `frame` index into the accumulator and issues read addresses to the coefficient and sample memories. At frame end it captures the accumulated sum, rescales it to the output sample width and presents it as the filter output `y` with a one-cycle valid.

## Interface
Parameters:
- `ACC_WIDTH`, 40: accumulator width; equals the accumulator's output width.
- `Y_WIDTH`, 16: width of the output sample.
- `SHIFT`, 15: arithmetic right shift applied to the accumulator (Q15 coefficients).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: new-sample strobe, one cycle.
- `frame`  out  7: frame index to the accumulator.
- `rd_en`  out  1: memory read enable.
- `rd_addr`  out  7: tap address, shared by the coefficient and sample memories.
- `acc_in`  in  ACC_WIDTH: accumulator output, signed.
- `y_out`  out  Y_WIDTH: filter output, signed, registered.
- `y_valid`  out  1: one-cycle pulse when `y_out` updates.
- `busy`  out  1: high while a frame is in progress.
- `overrun`  out  1: one-cycle pulse when `start` is rejected.
- `sat`  out  1: one-cycle pulse with `y_valid` when the output clipped.

## Operation
- States:
  - IDLE: `frame`=0, `busy`=0.
  - RUN: `frame` counts 0..127, `busy`=1.
- Transitions:
  - IDLE + `start` -> RUN, with `frame`=0 on the next cycle.
  - RUN with `frame`=127 -> IDLE, or straight back into RUN with `frame`=0 if `start` is high in that cycle (back-to-back frames).
- Memory reads:
  - `rd_en`=1 for `frame` 0..125; `rd_addr`=`frame`; otherwise `rd_en`=0 and `rd_addr`=0.
  - Memories have 1-cycle read latency, so tap k arrives during `frame`=k+1.
- Accumulation: the accumulator sums over `frame` 1..126 (taps 0..125) and clears whenever `frame` is 0 or 127.
- Capture:
  - On the edge ending `frame`=127: `y_out` <= scaled(`acc_in`) and `y_valid` <= 1.
  - `y_valid` deasserts the following cycle.
- Scaling:
  - `acc_in` is arithmetic-shifted right by `SHIFT` (floor, no rounding).
  - The result is then reduced to `Y_WIDTH` as set under Configuration.
- `start` while `busy` and `frame`≠127: ignored; `overrun` pulses for one cycle and the current frame continues unaffected.

## Timing
- `start` sampled at cycle t:
  - `frame`=0 at t+1.
  - `frame`=127 at t+128.
  - `y_valid` at t+129.
- `busy` is high for t+1..t+128.
- Back-to-back: `start` at `frame`=127 -> `frame`=0 on the next cycle; `y_valid` for the old frame coincides with `frame`=0 of the new one.
- Sustained throughput: one output per 128 cycles.
- Reset values: `frame`=0, `rd_en`=0, `rd_addr`=0, `y_out`=0, `y_valid`=0, `busy`=0, `overrun`=0, `sat`=0; state IDLE.
- Reset mid-frame: the next edge returns to IDLE with no `y_valid`. The accumulator clears because it sees `frame`=0.
- Reset wins over a `start` in the same cycle.

## Configuration
- `ANC_INP_SEQ_SAT_EN` defined:
  - The shifted value is clamped to [-2^(Y_WIDTH-1), 2^(Y_WIDTH-1)-1].
  - `sat` pulses with `y_valid` whenever the clamp engaged.
- Undefined:
  - `y_out` takes the low `Y_WIDTH` bits of the shifted value (two's-complement wrap).
  - `sat` is tied to 0.

## Structure
- Package `anc_pkg`:
  - `FRAME_LAST`=127, `TAP_LAST`=126, `RD_LAST`=125.
  - State enum {IDLE, RUN}.
  - 7-bit frame typedef.
- Sub-module `anc_frame_cnt`: 7-bit counter with synchronous clear and load-to-zero, plus a terminal flag at 127. The FSM, address decode and output scaler stay in the top level.

## Test plan
- Single frame; all 126 coefficients and samples = 16384; SAT_EN on -> `y_out`=32767, `sat`=1, `y_valid` exactly 129 cycles after `start`.
- Same stimulus, SAT_EN off -> `y_out`=-16384 (wrap of 1032192), `sat`=0.
- Only tap 0 coefficient = 16384, sample = 16384, all else 0 -> `y_out`=8192. Also check `rd_addr` sweeps 0..125 with `rd_en`, and is 0 at `frame` 126/127.
- `start` at `frame`=127 -> next `frame`=0, `busy` stays 1, two `y_valid` pulses 128 cycles apart. `start` at `frame`=60 -> `overrun` pulses and the frame completes normally.
- `rst_n` low for 1 cycle at `frame`=80 -> next cycle all outputs at reset values and no `y_valid`. A subsequent `start` produces a correct result with no residue from the aborted frame.
- Negative sum: tap 0 = -16384 × 16384 -> `y_out`=-8192, checking floor-shift sign handling.
